// File: rtl/hive_reg_error_log_pkg.sv
// Shared definitions for the Hive error log register block: rbus base
// address, thread-count default, capture FSM states and a width helper.
package hive_reg_error_log_pkg;

    // Default rbus location of the error log register set
    localparam int RBUS_ERROR_LOG = 'h10;

    // Default number of hardware threads in the Hive core
    localparam int HIVE_THREADS = 8;

    // First-error capture states
    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } err_fsm_t;

    // Bits needed to index n items, never less than one bit
    function automatic int min1_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hive_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment so a
// counting event in the clearing cycle is dropped.
module hive_sat_cnt
    import hive_reg_error_log_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_reg;

    // Clear has priority; otherwise count up and stick at all-ones
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (inc_i && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/hive_reg_error_log.sv
// Hive error log: sticky per-thread/per-source error flags, interrupt mask,
// first-error capture and (optionally) per-source saturating event counters,
// all on the rbus. Define HIVE_ERR_CNT_EN to build the COUNT registers; when
// it is undefined the COUNT addresses read 0 and ignore writes.
module hive_reg_error_log
    import hive_reg_error_log_pkg::*;
#(
    parameter int THREADS   = HIVE_THREADS,
    parameter int ERR_SRCS  = 4,
    parameter int CNT_W     = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = RBUS_ERROR_LOG
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [ADDR_W-1:0]            rbus_addr_i,
    input  logic                         rbus_wr_i,
    input  logic                         rbus_rd_i,
    input  logic [DATA_W-1:0]            rbus_wr_data_i,
    output logic [DATA_W-1:0]            rbus_rd_data_o,
    input  logic [ERR_SRCS*THREADS-1:0]  err_i,
    output logic                         err_irq_o
);

    localparam int THRD_W = $clog2(THREADS);
    localparam int SW     = min1_clog2(ERR_SRCS);
    localparam int NERR   = ERR_SRCS * THREADS;

    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(BASE_ADDR + 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST  = ADDR_W'(BASE_ADDR + 2);

    logic [NERR-1:0]   err_1_reg;
    logic [NERR-1:0]   status_reg;
    logic [NERR-1:0]   status_next;
    logic [NERR-1:0]   mask_reg;
    logic              wr_status;
    logic              wr_mask;
    logic              wr_first;

    err_fsm_t          state_reg;
    err_fsm_t          state_next;
    logic [SW-1:0]     first_src_reg;
    logic [SW-1:0]     first_src_next;
    logic [THRD_W-1:0] first_thr_reg;
    logic [THRD_W-1:0] first_thr_next;
    logic [SW-1:0]     hit_src;
    logic [THRD_W-1:0] hit_thr;
    logic              hit_any;
    logic [DATA_W-1:0] first_word;

    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_reg;
    logic              irq_reg;

    assign wr_status = rbus_wr_i && (rbus_addr_i == ADDR_STATUS);
    assign wr_mask   = rbus_wr_i && (rbus_addr_i == ADDR_MASK);
    assign wr_first  = rbus_wr_i && (rbus_addr_i == ADDR_FIRST);

    // Register the raw error pulses once; everything downstream uses err_1
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_1_reg <= '0;
        end else begin
            err_1_reg <= err_i;
        end
    end

    // Sticky flags: clear-on-write-1 first, then OR in new errors so a
    // simultaneous set survives the clear
    always_comb begin
        status_next = status_reg & ~(wr_status ? rbus_wr_data_i[NERR-1:0] : '0);
        status_next = status_next | err_1_reg;
    end

    // Status and mask registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            status_reg <= '0;
            mask_reg   <= '0;
        end else begin
            status_reg <= status_next;
            if (wr_mask) begin
                mask_reg <= rbus_wr_data_i[NERR-1:0];
            end
        end
    end

    // Lowest-index error in err_1: scanning downward lets the lowest hit win
    always_comb begin
        hit_src = '0;
        hit_thr = '0;
        hit_any = |err_1_reg;
        for (int s = ERR_SRCS - 1; s >= 0; s--) begin
            for (int t = THREADS - 1; t >= 0; t--) begin
                if (err_1_reg[s*THREADS + t]) begin
                    hit_src = SW'(s);
                    hit_thr = THRD_W'(t);
                end
            end
        end
    end

    // Capture FSM state and captured source/thread
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ARMED;
            first_src_reg <= '0;
            first_thr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            first_src_reg <= first_src_next;
            first_thr_reg <= first_thr_next;
        end
    end

    // Capture next-state: a FIRST write re-arms and beats any same-cycle error
    always_comb begin
        state_next     = state_reg;
        first_src_next = first_src_reg;
        first_thr_next = first_thr_reg;
        if (wr_first) begin
            state_next = ARMED;
        end else if ((state_reg == ARMED) && hit_any) begin
            state_next     = HELD;
            first_src_next = hit_src;
            first_thr_next = hit_thr;
        end
    end

    // FIRST register view; valid is simply "capture is being held"
    always_comb begin
        first_word                        = '0;
        first_word[DATA_W-1]              = (state_reg == HELD);
        first_word[THRD_W+SW-1:THRD_W]    = first_src_reg;
        first_word[THRD_W-1:0]            = first_thr_reg;
    end

`ifdef HIVE_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_val [ERR_SRCS];

    generate
        for (genvar gi = 0; gi < ERR_SRCS; gi++) begin : g_cnt
            localparam logic [ADDR_W-1:0] ADDR_CNT = ADDR_W'(BASE_ADDR + 3 + gi);
            logic cnt_clr;
            logic cnt_inc;

            assign cnt_clr = rbus_wr_i && (rbus_addr_i == ADDR_CNT);
            assign cnt_inc = |err_1_reg[gi*THREADS +: THREADS];

            hive_sat_cnt #(
                .W (CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .clr_i   (cnt_clr),
                .inc_i   (cnt_inc),
                .cnt_o   (cnt_val[gi])
            );
        end
    endgenerate
`endif

    // Read multiplexer; unmapped addresses fall through to zero
    always_comb begin
        rd_mux = '0;
        if (rbus_addr_i == ADDR_STATUS) begin
            rd_mux = DATA_W'(status_reg);
        end else if (rbus_addr_i == ADDR_MASK) begin
            rd_mux = DATA_W'(mask_reg);
        end else if (rbus_addr_i == ADDR_FIRST) begin
            rd_mux = first_word;
        end
`ifdef HIVE_ERR_CNT_EN
        for (int s = 0; s < ERR_SRCS; s++) begin
            if (rbus_addr_i == ADDR_W'(BASE_ADDR + 3 + s)) begin
                rd_mux = DATA_W'(cnt_val[s]);
            end
        end
`endif
    end

    // Registered read data (zero when idle for OR-combining) and interrupt
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            rd_data_reg <= rbus_rd_i ? rd_mux : '0;
            irq_reg     <= |(status_reg & mask_reg);
        end
    end

    assign rbus_rd_data_o = rd_data_reg;
    assign err_irq_o      = irq_reg;

endmodule

// File: tb/tb_hive_reg_error_log.sv
// Self-checking bench for hive_reg_error_log: directed scenarios plus a
// randomized run against a register-level reference model.
module tb_hive_reg_error_log;

    localparam int THREADS = 8;
    localparam int NSRC    = 4;
    localparam int CNT_W   = 4;
    localparam int BASE    = 'h10;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [7:0]  rbus_addr_i = '0;
    logic        rbus_wr_i = 1'b0;
    logic        rbus_rd_i = 1'b0;
    logic [31:0] rbus_wr_data_i = '0;
    logic [31:0] rbus_rd_data_o;
    logic [31:0] err_i = '0;
    logic        err_irq_o;

    int errors = 0;
    int checks = 0;

    // Reference model state (register contents as the spec describes them)
    logic [31:0] m_err1;
    logic [31:0] m_status;
    logic [31:0] m_mask;
    logic [31:0] m_rd;
    bit          m_irq;
    bit          m_valid;
    int          m_src;
    int          m_thr;
    int          m_cnt [NSRC];

    hive_reg_error_log #(
        .THREADS   (THREADS),
        .ERR_SRCS  (NSRC),
        .CNT_W     (CNT_W),
        .DATA_W    (32),
        .ADDR_W    (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rbus_addr_i    (rbus_addr_i),
        .rbus_wr_i      (rbus_wr_i),
        .rbus_rd_i      (rbus_rd_i),
        .rbus_wr_data_i (rbus_wr_data_i),
        .rbus_rd_data_o (rbus_rd_data_o),
        .err_i          (err_i),
        .err_irq_o      (err_irq_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int off;
        off = int'(a) - BASE;
        if (off == 0) return m_status;
        if (off == 1) return m_mask;
        if (off == 2) return ({31'd0, m_valid} << 31) | 32'(m_src * THREADS + m_thr);
        if (off >= 3 && off < 3 + NSRC) begin
`ifdef HIVE_ERR_CNT_EN
            return 32'(m_cnt[off-3]);
`else
            return 32'd0;
`endif
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_err1 = '0; m_status = '0; m_mask = '0; m_rd = '0;
        m_irq = 0; m_valid = 0; m_src = 0; m_thr = 0;
        for (int s = 0; s < NSRC; s++) m_cnt[s] = 0;
    endtask

    // One bus cycle: drive at negedge, advance DUT and model across posedge,
    // return at the following negedge with the inputs parked idle
    task automatic cycle(input logic [31:0] err, input bit rd, input bit wr,
                         input logic [7:0] addr, input logic [31:0] wdata);
        logic [31:0] nrd;
        bit          nirq;
        int          off;
        int          idx;
        err_i = err; rbus_rd_i = rd; rbus_wr_i = wr;
        rbus_addr_i = addr; rbus_wr_data_i = wdata;
        @(posedge clk_i);
        nrd  = rd ? model_read(addr) : 32'd0;
        nirq = |(m_status & m_mask);
        off  = int'(addr) - BASE;
        if (wr && off == 0) m_status = m_status & ~wdata;
        m_status = m_status | m_err1;
        if (wr && off == 1) m_mask = wdata;
        for (int s = 0; s < NSRC; s++) begin
            if (wr && off == 3 + s) m_cnt[s] = 0;
            else if (((m_err1 >> (s * THREADS)) & 32'hFF) != 0)
                m_cnt[s] = (m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX;
        end
        if (wr && off == 2) begin
            m_valid = 0;
        end else if (!m_valid && m_err1 != 0) begin
            idx = 0;
            for (int i = 31; i >= 0; i--) if (m_err1[i]) idx = i;
            m_src = idx / THREADS;
            m_thr = idx % THREADS;
            m_valid = 1;
        end
        m_err1 = err; m_rd = nrd; m_irq = nirq;
        @(negedge clk_i);
        err_i = '0; rbus_rd_i = 0; rbus_wr_i = 0; rbus_addr_i = '0; rbus_wr_data_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'd0, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic rd(input int a);
        cycle(32'd0, 1, 0, 8'(a), 32'd0);
        $display("read  addr=%02h data=%08h irq=%0b", 8'(a), rbus_rd_data_o, err_irq_o);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(32'd0, 0, 1, 8'(a), d);
        $display("write addr=%02h data=%08h", 8'(a), d);
    endtask

    task automatic test_reset();
        rst_n_i = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_rd: got %08h expected 0", rbus_rd_data_o); end
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", err_irq_o); end
        rst_n_i = 1;
        for (int a = BASE - 1; a <= BASE + 3 + NSRC; a++) begin
            rd(a);
            checks++;
            if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_reg%02h: got %08h expected 0", a, rbus_rd_data_o); end
        end
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %0b expected 0", err_irq_o); end
    endtask

    task automatic test_single_error();
        cycle(32'h200, 0, 0, 8'd0, 32'd0);
        rd(BASE);   // samples STATUS one cycle too early to see the error
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL single_status_early: got %08h expected 0", rbus_rd_data_o); end
        rd(BASE);
        checks++;
        if (rbus_rd_data_o !== 32'h200) begin errors++; $display("FAIL single_status: got %08h expected 00000200", rbus_rd_data_o); end
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o !== 32'h80000009) begin errors++; $display("FAIL single_first: got %08h expected 80000009", rbus_rd_data_o); end
        rd(BASE + 4);
        checks++;
`ifdef HIVE_ERR_CNT_EN
        if (rbus_rd_data_o !== 32'd1) begin errors++; $display("FAIL single_count1: got %08h expected 1", rbus_rd_data_o); end
`else
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL single_count1: got %08h expected 0", rbus_rd_data_o); end
`endif
    endtask

    task automatic test_irq();
        wr(BASE, 32'hFFFF_FFFF);
        wr(BASE + 2, 32'd0);
        wr(BASE + 1, 32'h200);
        idle(2);
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle: got %0b expected 0", err_irq_o); end
        cycle(32'h200, 0, 0, 8'd0, 32'd0);
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL irq_n1: got %0b expected 0", err_irq_o); end
        idle(1);
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL irq_n2: got %0b expected 0", err_irq_o); end
        idle(1);
        checks++;
        if (err_irq_o !== 1'b1) begin errors++; $display("FAIL irq_n3: got %0b expected 1", err_irq_o); end
        wr(BASE, 32'h200);
        checks++;
        if (err_irq_o !== 1'b1) begin errors++; $display("FAIL irq_clear_w1: got %0b expected 1", err_irq_o); end
        idle(1);
        checks++;
        if (err_irq_o !== 1'b0 || m_irq !== 1'b0) begin errors++; $display("FAIL irq_clear_w2: got %0b expected 0", err_irq_o); end
    endtask

    task automatic test_first();
        wr(BASE, 32'hFFFF_FFFF);
        wr(BASE + 2, 32'd0);
        cycle(32'h108, 0, 0, 8'd0, 32'd0);
        cycle(32'h001, 0, 0, 8'd0, 32'd0);
        idle(2);
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o !== 32'h80000003) begin errors++; $display("FAIL first_lowest: got %08h expected 80000003", rbus_rd_data_o); end
        wr(BASE + 2, 32'd0);
        cycle(32'h001, 0, 0, 8'd0, 32'd0);
        idle(2);
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o !== 32'h80000000) begin errors++; $display("FAIL first_rearm: got %08h expected 80000000", rbus_rd_data_o); end
        // re-arm write in the same cycle a new error reaches err_1
        cycle(32'h020, 0, 0, 8'd0, 32'd0);
        cycle(32'd0, 0, 1, 8'(BASE + 2), 32'd0);
        idle(1);
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o[31] !== 1'b0 || rbus_rd_data_o !== m_rd) begin errors++; $display("FAIL first_collide: got %08h expected %08h", rbus_rd_data_o, m_rd); end
        cycle(32'h004, 0, 0, 8'd0, 32'd0);
        idle(2);
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o !== 32'h80000002) begin errors++; $display("FAIL first_after_collide: got %08h expected 80000002", rbus_rd_data_o); end
    endtask

    task automatic test_status_collision();
        wr(BASE, 32'hFFFF_FFFF);
        cycle(32'h020, 0, 0, 8'd0, 32'd0);
        cycle(32'd0, 0, 1, 8'(BASE), 32'h20);
        rd(BASE);
        checks++;
        if (rbus_rd_data_o !== 32'h20) begin errors++; $display("FAIL status_set_wins: got %08h expected 00000020", rbus_rd_data_o); end
        wr(BASE, 32'h20);
        rd(BASE);
        checks++;
        if (rbus_rd_data_o !== 32'h0) begin errors++; $display("FAIL status_cow1: got %08h expected 0", rbus_rd_data_o); end
    endtask

    task automatic test_count();
`ifdef HIVE_ERR_CNT_EN
        wr(BASE + 5, 32'd0);
        for (int i = 0; i < 20; i++) cycle(32'd1 << (16 + $urandom_range(0, 7)), 0, 0, 8'd0, 32'd0);
        idle(2);
        rd(BASE + 5);
        checks++;
        if (rbus_rd_data_o !== 32'd15) begin errors++; $display("FAIL count_saturate: got %08h expected 0000000f", rbus_rd_data_o); end
        cycle(32'h0001_0000, 0, 0, 8'd0, 32'd0);
        cycle(32'd0, 0, 1, 8'(BASE + 5), 32'd0);
        idle(1);
        rd(BASE + 5);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL count_clear_wins: got %08h expected 0", rbus_rd_data_o); end
`else
        cycle(32'hFFFF_FFFF, 0, 0, 8'd0, 32'd0);
        idle(2);
        for (int s = 0; s < NSRC; s++) begin
            rd(BASE + 3 + s);
            checks++;
            if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL count_absent%0d: got %08h expected 0", s, rbus_rd_data_o); end
        end
`endif
    endtask

    task automatic test_rw_same();
        wr(BASE + 1, 32'h1234);
        cycle(32'd0, 1, 1, 8'(BASE + 1), 32'h5678);
        checks++;
        if (rbus_rd_data_o !== 32'h1234) begin errors++; $display("FAIL rw_pre_write: got %08h expected 00001234", rbus_rd_data_o); end
        rd(BASE + 1);
        checks++;
        if (rbus_rd_data_o !== 32'h5678) begin errors++; $display("FAIL rw_post_write: got %08h expected 00005678", rbus_rd_data_o); end
        idle(1);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL rd_returns_zero: got %08h expected 0", rbus_rd_data_o); end
    endtask

    task automatic test_unmapped();
        wr(BASE + 3 + NSRC, 32'hFFFF_FFFF);
        wr(0, 32'hFFFF_FFFF);
        rd(BASE + 3 + NSRC);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL unmapped_hi: got %08h expected 0", rbus_rd_data_o); end
        rd(BASE - 1);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL unmapped_lo: got %08h expected 0", rbus_rd_data_o); end
        rd(BASE + 1);
        checks++;
        if (rbus_rd_data_o !== 32'h5678) begin errors++; $display("FAIL unmapped_mask_kept: got %08h expected 00005678", rbus_rd_data_o); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        int op;
        int a;
        for (int n = 0; n < 400; n++) begin
            e  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
            op = $urandom_range(0, 3);
            a  = BASE - 1 + $urandom_range(0, 8);
            cycle(e, op[0], op[1], 8'(a), $urandom);
            $display("txn %0d err=%08h rd=%0b wr=%0b addr=%02h data=%08h irq=%0b", n, e, op[0], op[1], 8'(a), rbus_rd_data_o, err_irq_o);
            checks++;
            if (rbus_rd_data_o !== m_rd) begin errors++; $display("FAIL rand_rd txn %0d: got %08h expected %08h", n, rbus_rd_data_o, m_rd); end
            checks++;
            if (err_irq_o !== m_irq) begin errors++; $display("FAIL rand_irq txn %0d: got %0b expected %0b", n, err_irq_o, m_irq); end
        end
    endtask

    task automatic test_async_reset();
        wr(BASE + 1, 32'hFFFF_FFFF);
        cycle(32'h1, 0, 0, 8'd0, 32'd0);
        idle(2);
        cycle(32'hF0F0, 1, 0, 8'(BASE), 32'd0);
        checks++;
        if (err_irq_o !== 1'b1 || rbus_rd_data_o === 32'd0) begin errors++; $display("FAIL areset_pre: irq=%0b rd=%08h expected irq 1 and nonzero rd", err_irq_o, rbus_rd_data_o); end
        #2 rst_n_i = 0;
        #1;
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL areset_rd: got %08h expected 0", rbus_rd_data_o); end
        checks++;
        if (err_irq_o !== 1'b0) begin errors++; $display("FAIL areset_irq: got %0b expected 0", err_irq_o); end
        @(negedge clk_i);
        rst_n_i = 1;
        model_reset();
        idle(2);
        rd(BASE);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL areset_pending_dropped: got %08h expected 0", rbus_rd_data_o); end
        rd(BASE + 2);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL areset_first: got %08h expected 0", rbus_rd_data_o); end
        rd(BASE + 1);
        checks++;
        if (rbus_rd_data_o !== 32'd0) begin errors++; $display("FAIL areset_mask: got %08h expected 0", rbus_rd_data_o); end
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_irq();
        test_first();
        test_status_collision();
        test_count();
        test_rw_same();
        test_unmapped();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hive_reg_error_log.md
# hive_reg_error_log

Parametrised error tracker for the Hive core, successor to the single-register error block. It latches per-thread, per-source sticky error flags, counts events per source with saturating counters, and captures the first error since re-arm. It raises a masked interrupt. Sits on the rbus beside the other core register sets; error sources come from the control-ring pipeline.

## Interface
- THREADS, 8, thread count; THRD_W = $clog2(THREADS).
- ERR_SRCS, 4, error source count; ERR_SRCS*THREADS ≤ DATA_W.
- CNT_W, 8, per-source counter width, 1..DATA_W.
- DATA_W, 32, rbus data width.
- ADDR_W, 8, rbus address width.
- BASE_ADDR, 'h10, first register address; occupies BASE_ADDR..BASE_ADDR+3+ERR_SRCS-1.
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous reset, active-low.
- rbus_addr_i  in  ADDR_W  register address.
- rbus_wr_i  in  1  write enable, active high.
- rbus_rd_i  in  1  read enable, active high.
- rbus_wr_data_i  in  DATA_W  write data.
- rbus_rd_data_o  out  DATA_W  read data; 0 when not addressed, so it can be OR-combined on the bus.
- err_i  in  ERR_SRCS*THREADS  error pulses, source-major; bit s*THREADS+t = source s, thread t.
- err_irq_o  out  1  error interrupt, active high.

## Operation
- err_i is registered once (err_1) before any use.
- STATUS (BASE+0): sticky flags, bit s*THREADS+t. A set bit in err_1 sets the flag. Writes are clear-on-write-1 (COW1). Upper bits read 0.
- MASK (BASE+1): read/write interrupt enables, same bit layout. Reset value is 0.
- FIRST (BASE+2): bit DATA_W-1 = valid; bits [THRD_W+SW-1:THRD_W] = source; bits [THRD_W-1:0] = thread; SW = $clog2(ERR_SRCS), minimum 1.
  - Capture FSM has two states, ARMED and HELD.
  - ARMED: if err_1 ≠ 0, capture the lowest set bit index (lowest source, then lowest thread), set valid, go to HELD.
  - HELD: ignore new errors. Any write to FIRST clears valid and returns to ARMED.
- COUNT[s] (BASE+3+s): per-source counter, zero-extended to DATA_W.
  - Increments by 1 in any cycle where any thread bit of source s in err_1 is set.
  - Saturates at all-ones.
  - Any write clears it to 0.
- err_irq_o is the registered value of |(STATUS & MASK).
- Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.

## Timing
- Reset: STATUS, MASK, COUNT, FIRST and err_irq_o = 0; FSM = ARMED; rbus_rd_data_o = 0.
- Error at cycle n on err_i: err_1 at n+1, STATUS/COUNT/FIRST updated at n+2, err_irq_o at n+3.
- Read: rbus_rd_i at cycle n gives registered rbus_rd_data_o at n+1, then 0 at n+2 unless the read repeats.
- Write takes effect in the cycle after rbus_wr_i.
- Set and clear collide on the same STATUS bit in the same cycle: set wins (bit stays 1).
- Counter increment collides with a clear write: counter = 0; that event is dropped.
- FIRST write in HELD collides with a new err_1: clear wins. FSM returns to ARMED and captures the next error after that.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- rst_n_i asserted mid-operation clears everything immediately, including pending err_1.

## Configuration
- HIVE_ERR_CNT_EN
  - Defined: COUNT registers are present as above.
  - Undefined: no counter flops; COUNT addresses read 0 and writes are ignored. STATUS, MASK and FIRST are unchanged.

## Structure
- hive_defines provides the RBUS_ERROR_LOG base address.
- hive_params provides the THREADS default.
- hive_types provides ERR_FSM_T (ARMED, HELD).
- One sub-module, hive_sat_cnt: parametrised saturating counter with clear and inc inputs, clear-priority. Instantiated ERR_SRCS times under generate.

## Test plan
- Reset, then read all registers → all 0, err_irq_o = 0.
- err_i bit 9 (source 1, thread 1, THREADS=8) for 1 cycle → STATUS = 'h200 and FIRST = valid|src1|thr1 at n+2. COUNT[1] = 1.
- MASK = 'h200, err_i bit 9 → err_irq_o = 1 at n+3. Write STATUS 'h200 → err_irq_o drops 2 cycles after the write.
- err_i bits 3 and 8 in the same cycle, then bit 0 the next cycle → FIRST = src0|thr3 and stays there. Write FIRST, then bit 0 → FIRST = src0|thr0.
- CNT_W=4, hold source 2 active for 20 cycles → COUNT[2] = 15. Write COUNT[2] in the same cycle as an event → 0.
- STATUS COW1 write of bit 5 in the same cycle err_1 bit 5 is set → bit 5 remains 1. With HIVE_ERR_CNT_EN undefined → COUNT reads 0.
